// File: rtl/bfu_stream.sv
// rtl/bfu_stream.sv - pipelined radix-2 DIT butterfly with stream handshake
//
// Computes out_a = a + b*w and out_b = a - b*w on complex fixed-point samples
// through four pipeline stages that advance together under backpressure.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  input handshake; in_ready = !out_valid || out_ready
//   in_a, in_b           {re, im} signed DATA_W-bit components, re upper
//   twiddle              {wr, wi} signed Q1.(TW_W-1)
//   inverse              conjugate the twiddle for this sample
//   scale                halve both results with rounding for this sample
//   out_valid/out_ready  output handshake; outputs held while stalled
//   out_a, out_b         {re, im} saturated results
//   sat_flag / sat_clr   sticky saturation flag and its synchronous clear
`timescale 1ns/1ps
module bfu_stream #(
  parameter int DATA_W = 32,
  parameter int TW_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_a,
  input  logic [2*DATA_W-1:0] in_b,
  input  logic [2*TW_W-1:0]   twiddle,
  input  logic                inverse,
  input  logic                scale,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_a,
  output logic [2*DATA_W-1:0] out_b,
  output logic                sat_flag,
  input  logic                sat_clr
);

  localparam int EW = TW_W + 1;           // expanded twiddle width
  localparam int PW = DATA_W + TW_W + 1;  // product width
  localparam int RW = DATA_W + 2;         // rounded product width
  localparam int SW = DATA_W + 3;         // add/subtract width

  localparam logic signed [PW:0] RND =
    {{(PW + 2 - TW_W){1'b0}}, 1'b1, {(TW_W - 2){1'b0}}};
  localparam logic signed [SW-1:0] ONE_S = 1;
  localparam logic signed [SW-1:0] MAX_S = {{(SW - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_S = {{(SW - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  // 0x7fff is treated as exactly +1.0 so unity twiddles pass data unchanged.
  function automatic logic signed [EW-1:0] expand(input logic [TW_W-1:0] c);
    if (c == {1'b0, {(TW_W - 1){1'b1}}})
      return {2'b01, {(TW_W - 1){1'b0}}};
    else
      return {c[TW_W-1], c};
  endfunction

  // Optional rounded halving, then clamp; bit DATA_W reports a clamp.
  function automatic logic [DATA_W:0] finish(input logic signed [SW-1:0] x, input logic sc);
    logic signed [SW-1:0] y;
    y = sc ? ((x + ONE_S) >>> 1) : x;
    if (y > MAX_S)      return {1'b1, MAX_S[DATA_W-1:0]};
    else if (y < MIN_S) return {1'b1, MIN_S[DATA_W-1:0]};
    else                return {1'b0, y[DATA_W-1:0]};
  endfunction

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Twiddle expansion ahead of stage 1; negation in EW bits cannot overflow.
  logic signed [EW-1:0] w_r_x, w_i_e, w_i_x;
  assign w_r_x = expand(twiddle[2*TW_W-1:TW_W]);
  assign w_i_e = expand(twiddle[TW_W-1:0]);
  assign w_i_x = inverse ? -w_i_e : w_i_e;

  // Stage registers
  logic                     s1_v, s2_v, s3_v;
  logic                     s1_sc, s2_sc, s3_sc;
  logic signed [DATA_W-1:0] s1_ar, s1_ai, s1_br, s1_bi;
  logic signed [EW-1:0]     s1_wr, s1_wi;
  logic signed [DATA_W-1:0] s2_ar, s2_ai;
  logic signed [PW-1:0]     s2_rr, s2_ii, s2_ri, s2_ir;
  logic signed [DATA_W-1:0] s3_ar, s3_ai;
  logic signed [RW-1:0]     s3_pr, s3_pi;

  // Operands sign-extended to full product width before multiplying.
  logic signed [PW-1:0] x_br, x_bi, x_wr, x_wi;
  assign x_br = {{(PW - DATA_W){s1_br[DATA_W-1]}}, s1_br};
  assign x_bi = {{(PW - DATA_W){s1_bi[DATA_W-1]}}, s1_bi};
  assign x_wr = {{(PW - EW){s1_wr[EW-1]}}, s1_wr};
  assign x_wi = {{(PW - EW){s1_wi[EW-1]}}, s1_wi};

  // Stage 3 combine and round half-up
  logic signed [PW:0] pr_sum, pi_sum, pr_shift, pi_shift;
  always_comb begin
    pr_sum   = {s2_rr[PW-1], s2_rr} - {s2_ii[PW-1], s2_ii};
    pi_sum   = {s2_ri[PW-1], s2_ri} + {s2_ir[PW-1], s2_ir};
    pr_shift = (pr_sum + RND) >>> (TW_W - 1);
    pi_shift = (pi_sum + RND) >>> (TW_W - 1);
  end

  // Stage 4 add/subtract, scale and saturate
  logic signed [SW-1:0] sum_re, sum_im, dif_re, dif_im;
  logic [DATA_W:0]      f_ar, f_ai, f_br, f_bi;
  logic                 any_clamp;
  always_comb begin
    sum_re    = {{3{s3_ar[DATA_W-1]}}, s3_ar} + {s3_pr[RW-1], s3_pr};
    sum_im    = {{3{s3_ai[DATA_W-1]}}, s3_ai} + {s3_pi[RW-1], s3_pi};
    dif_re    = {{3{s3_ar[DATA_W-1]}}, s3_ar} - {s3_pr[RW-1], s3_pr};
    dif_im    = {{3{s3_ai[DATA_W-1]}}, s3_ai} - {s3_pi[RW-1], s3_pi};
    f_ar      = finish(sum_re, s3_sc);
    f_ai      = finish(sum_im, s3_sc);
    f_br      = finish(dif_re, s3_sc);
    f_bi      = finish(dif_im, s3_sc);
    any_clamp = f_ar[DATA_W] | f_ai[DATA_W] | f_br[DATA_W] | f_bi[DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s3_v <= 1'b0; out_valid <= 1'b0;
      s1_sc <= 1'b0; s2_sc <= 1'b0; s3_sc <= 1'b0;
      s1_ar <= '0; s1_ai <= '0; s1_br <= '0; s1_bi <= '0;
      s1_wr <= '0; s1_wi <= '0;
      s2_ar <= '0; s2_ai <= '0;
      s2_rr <= '0; s2_ii <= '0; s2_ri <= '0; s2_ir <= '0;
      s3_ar <= '0; s3_ai <= '0; s3_pr <= '0; s3_pi <= '0;
      out_a <= '0; out_b <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (advance) begin
        s1_v  <= in_valid;
        s1_sc <= scale;
        s1_ar <= in_a[2*DATA_W-1:DATA_W];
        s1_ai <= in_a[DATA_W-1:0];
        s1_br <= in_b[2*DATA_W-1:DATA_W];
        s1_bi <= in_b[DATA_W-1:0];
        s1_wr <= w_r_x;
        s1_wi <= w_i_x;

        s2_v  <= s1_v;
        s2_sc <= s1_sc;
        s2_ar <= s1_ar;
        s2_ai <= s1_ai;
        s2_rr <= x_br * x_wr;
        s2_ii <= x_bi * x_wi;
        s2_ri <= x_br * x_wi;
        s2_ir <= x_bi * x_wr;

        s3_v  <= s2_v;
        s3_sc <= s2_sc;
        s3_ar <= s2_ar;
        s3_ai <= s2_ai;
        s3_pr <= pr_shift[RW-1:0];
        s3_pi <= pi_shift[RW-1:0];

        out_valid <= s3_v;
        if (s3_v) begin
          out_a <= {f_ar[DATA_W-1:0], f_ai[DATA_W-1:0]};
          out_b <= {f_br[DATA_W-1:0], f_bi[DATA_W-1:0]};
        end
      end

      // Set has priority over clear.
      if (advance && s3_v && any_clamp)
        sat_flag <= 1'b1;
      else if (sat_clr)
        sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bfu_stream.sv
// tb/tb_bfu_stream.sv - self-checking bench for bfu_stream
`timescale 1ns/1ps
module tb_bfu_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_a = '0, in_b = '0;
  logic [31:0] twiddle = '0;
  logic        inverse = 1'b0, scale = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_a, out_b;
  logic        sat_flag;
  logic        sat_clr = 1'b0;

  bfu_stream #(.DATA_W(32), .TW_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .twiddle(twiddle),
    .inverse(inverse), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .sat_flag(sat_flag), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    bit          clamp;
  } exp_t;

  exp_t        q[$];
  bit          prev_stall = 0;
  logic [63:0] prev_a, prev_b;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_checks++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, got, req);
  endtask

  // Reference arithmetic on plain integers.
  function automatic longint tw_val(input logic [15:0] c);
    if (c == 16'h7fff) return 64'sd32768;
    return longint'($signed(c));
  endfunction

  function automatic logic [31:0] fin(input longint x, input bit sc, inout bit cl);
    longint y;
    y = sc ? ((x + 1) >>> 1) : x;
    if (y > 64'sd2147483647)  begin cl = 1; return 32'h7fff_ffff; end
    if (y < -64'sd2147483648) begin cl = 1; return 32'h8000_0000; end
    return y[31:0];
  endfunction

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [31:0] tw, input bit inv, input bit sc);
    exp_t   e;
    longint ar, ai, br, bi, wr, wi, pr, pi;
    bit     cl;
    cl = 0;
    ar = longint'($signed(a[63:32]));
    ai = longint'($signed(a[31:0]));
    br = longint'($signed(b[63:32]));
    bi = longint'($signed(b[31:0]));
    wr = tw_val(tw[31:16]);
    wi = tw_val(tw[15:0]);
    if (inv) wi = -wi;
    pr = (br * wr - bi * wi + 16384) >>> 15;
    pi = (br * wi + bi * wr + 16384) >>> 15;
    e.a[63:32] = fin(ar + pr, sc, cl);
    e.a[31:0]  = fin(ai + pi, sc, cl);
    e.b[63:32] = fin(ar - pr, sc, cl);
    e.b[31:0]  = fin(ai - pi, sc, cl);
    e.clamp    = cl;
    return e;
  endfunction

  // Compare process: inputs and out_ready change just after posedge, so the
  // negedge view is what the next posedge will act on.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      prev_stall = 0;
    end else begin
      check("in_ready_rule", {63'b0, in_ready}, {63'b0, !(out_valid && !out_ready)});
      if (prev_stall) begin
        check("stall_valid", {63'b0, out_valid}, 64'd1);
        check("stall_out_a", out_a, prev_a);
        check("stall_out_b", out_b, prev_b);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_out: got output a=%h with no sample pending, required none", out_a);
        end else begin
          e = q.pop_front();
          check("out_a", out_a, e.a);
          check("out_b", out_b, e.b);
          if (e.clamp) check("sat_flag_set", {63'b0, sat_flag}, 64'd1);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_a = out_a;
      prev_b = out_b;
      if (in_valid && in_ready) q.push_back(model(in_a, in_b, twiddle, inverse, scale));
    end
  end

  // One isolated sample with out_ready high; measures clocks until out_valid.
  task automatic send_one(input logic [63:0] a, input logic [63:0] b, input logic [31:0] tw,
                          input bit inv, input bit sc,
                          output logic [63:0] oa, output logic [63:0] ob);
    int k;
    @(posedge clk); #1;
    in_a = a; in_b = b; twiddle = tw; inverse = inv; scale = sc;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency", 64'(k), 64'd4);
    oa = out_a;
    ob = out_b;
  endtask

  task automatic drive_random;
    int r;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    r = $urandom_range(0, 7);
    twiddle = {$urandom} & 32'hffff_ffff;
    if (r == 0) twiddle[31:16] = 16'h7fff;
    if (r == 1) twiddle[31:16] = 16'h8000;
    if (r == 2) twiddle[15:0]  = 16'h7fff;
    inverse = 1'($urandom_range(0, 1));
    scale   = 1'($urandom_range(0, 1));
  endtask

  task automatic drain;
    int g;
    in_valid = 1'b0;
    out_ready = 1'b1;
    g = 0;
    while ((q.size() != 0 || out_valid) && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] oa, ob;
    exp_t        m;
    int          idx, guard;
    bit          acc;

    // Model pinned against hand-computed values.
    m = model({32'h0001_0000, 32'h0}, {32'h0001_0000, 32'h0}, 32'h7fff_0000, 0, 0);
    check("model_identity_a", m.a, {32'h0002_0000, 32'h0});
    m = model(64'h0, {32'h0000_0001, 32'h0}, 32'h4000_0000, 0, 0);
    check("model_round_a", m.a, {32'h0000_0001, 32'h0});

    // Reset state
    #12;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_a", out_a, 64'd0);
    check("rst_out_b", out_b, 64'd0);
    check("rst_sat_flag", {63'b0, sat_flag}, 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);

    // Identity
    send_one({32'h0001_0000, 32'h0}, {32'h0001_0000, 32'h0}, 32'h7fff_0000, 0, 0, oa, ob);
    check("identity_a", oa, {32'h0002_0000, 32'h0});
    check("identity_b", ob, 64'h0);

    // Twiddle j, forward and inverse
    send_one(64'h0, {32'h0001_0000, 32'h0}, 32'h0000_7fff, 0, 0, oa, ob);
    check("j_fwd_a", oa, {32'h0, 32'h0001_0000});
    check("j_fwd_b", ob, {32'h0, 32'hffff_0000});
    send_one(64'h0, {32'h0001_0000, 32'h0}, 32'h0000_7fff, 1, 0, oa, ob);
    check("j_inv_a", oa, {32'h0, 32'hffff_0000});
    check("j_inv_b", ob, {32'h0, 32'h0001_0000});

    // Minus one and rounding
    send_one(64'h0, {32'h0000_8000, 32'h0}, 32'h8000_0000, 0, 0, oa, ob);
    check("neg1_a_re", {32'h0, oa[63:32]}, {32'h0, 32'hffff_8000});
    check("neg1_b_re", {32'h0, ob[63:32]}, {32'h0, 32'h0000_8000});
    send_one(64'h0, {32'h0000_0001, 32'h0}, 32'h4000_0000, 0, 0, oa, ob);
    check("round_a_re", {32'h0, oa[63:32]}, 64'd1);

    // Saturation, clear, then scaling
    send_one({32'h7fff_ffff, 32'h0}, {32'h7fff_ffff, 32'h0}, 32'h7fff_0000, 0, 0, oa, ob);
    check("sat_a_re", {32'h0, oa[63:32]}, {32'h0, 32'h7fff_ffff});
    check("sat_b_re", {32'h0, ob[63:32]}, 64'd0);
    check("sat_flag_on", {63'b0, sat_flag}, 64'd1);
    @(posedge clk); #1 sat_clr = 1'b1;
    @(posedge clk); #1 sat_clr = 1'b0;
    check("sat_flag_cleared", {63'b0, sat_flag}, 64'd0);
    send_one({32'h7fff_ffff, 32'h0}, {32'h7fff_ffff, 32'h0}, 32'h7fff_0000, 0, 1, oa, ob);
    check("scale_a_re", {32'h0, oa[63:32]}, {32'h0, 32'h7fff_ffff});
    check("scale_flag_off", {63'b0, sat_flag}, 64'd0);
    @(posedge clk); #1;

    // Backpressure: 8 samples, out_ready toggling
    idx = 0; guard = 0;
    drive_random();
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (idx < 8 && guard < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        idx++;
        drive_random();
      end
      in_valid  = (idx < 8);
      out_ready = ~out_ready;
    end
    check("bp_all_accepted", 64'(idx), 64'd8);
    guard = 0;
    while ((q.size() != 0 || out_valid) && guard < 60) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
      guard++;
    end
    check("bp_drained", 64'(q.size()), 64'd0);
    drain();

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      drive_random();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    drain();
    @(posedge clk); #1 sat_clr = 1'b1;
    @(posedge clk); #1 sat_clr = 1'b0;

    // Reset with three samples in flight behind a saturating one
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_a = {32'h7fff_ffff, 32'h0}; in_b = {32'h7fff_ffff, 32'h0};
    twiddle = 32'h7fff_0000; inverse = 0; scale = 0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive_random();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_valid", {63'b0, out_valid}, 64'd1);
    check("pre_rst_flag", {63'b0, sat_flag}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("mid_rst_out_a", out_a, 64'd0);
    check("mid_rst_out_b", out_b, 64'd0);
    check("mid_rst_sat_flag", {63'b0, sat_flag}, 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle", {63'b0, out_valid}, 64'd0);
    end
    send_one({32'h0001_0000, 32'h0}, {32'h0001_0000, 32'h0}, 32'h7fff_0000, 0, 0, oa, ob);
    check("post_rst_a", oa, {32'h0002_0000, 32'h0});
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bfu_stream.md
# bfu_stream

Parametrised, fully pipelined radix-2 decimation-in-time butterfly for the FFT datapath. It computes out_a = a + b·w and out_b = a − b·w on complex fixed-point samples. It adds four capabilities: a valid/ready stream handshake with backpressure, an inverse-transform mode that conjugates the twiddle, optional per-stage ÷2 scaling, and saturating outputs with a sticky overflow flag. It sits between stage reorder buffers and the twiddle ROM, one instance per FFT stage.

## Interface
- DATA_W, 32, width of each signed real/imag data component (Q(DATA_W−16).16 in the default build)
- TW_W, 16, width of each signed twiddle component, format Q1.(TW_W−1)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept an input this cycle
- in_a  in  2·DATA_W  {re, im}, re in the upper half
- in_b  in  2·DATA_W  {re, im}
- twiddle  in  2·TW_W  {wr, wi}
- inverse  in  1  1 = use the conjugate twiddle; sampled with the data
- scale  in  1  1 = halve both outputs with rounding; sampled with the data
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts the output
- out_a, out_b  out  2·DATA_W  {re, im} results
- sat_flag  out  1  sticky flag: some output component has saturated
- sat_clr  in  1  synchronous clear of sat_flag

## Operation
- Accept: a sample is taken on a rising edge where in_valid && in_ready. inverse and scale travel down the pipe with that sample.
- Twiddle expansion to TW_W+1 bits signed: a component equal to 2^(TW_W−1)−1 (0x7fff) maps to exactly +2^(TW_W−1), i.e. +1.0. All other values are sign-extended. If inverse=1, wi is negated in TW_W+1 bits, so it never overflows.
- Stage 1: register a, b and the expanded w.
- Stage 2: register the four products br·wr, bi·wi, br·wi, bi·wr, each DATA_W+TW_W+1 bits.
- Stage 3:
  - pr = br·wr − bi·wi and pi = br·wi + bi·wr.
  - Round half-up: add 2^(TW_W−2), then arithmetic shift right by TW_W−1.
  - Keep DATA_W+2 bits and register; a is delayed alongside.
- Stage 4:
  - s = a + p and d = a − p, computed in DATA_W+3 bits.
  - If scale: x = (x + 1) >>> 1.
  - Saturate each component to [−2^(DATA_W−1), 2^(DATA_W−1)−1] and register to the outputs.
- sat_flag is set on any output component whose value was clamped, evaluated when the sample is registered into stage 4. It clears when sat_clr=1. If set and clear happen in the same cycle, set wins.
- Flow control:
  - advance = !out_valid || out_ready, and in_ready = advance.
  - All four stages and their valid bits shift together only when advance=1. Otherwise every register holds.
  - Bubbles are not compressed.

## Timing
- Reset (asynchronous, rst_n=0):
  - all stage valid bits, out_valid and sat_flag go to 0;
  - out_a and out_b go to 0;
  - in_ready = 1 after release.
- In-flight samples are discarded on reset; nothing stale appears after release.
- Latency: 4 advancing cycles from accept to out_valid. With out_ready held at 1, out_valid rises 4 clocks after the accepting edge.
- Throughput: 1 sample per clock while out_ready=1.
- out_a, out_b and out_valid are registered and stay stable while out_valid && !out_ready.
- in_ready is combinational from out_valid and out_ready. in_ready = 0 exactly when out_valid && !out_ready.
- A twiddle of (0x8000, 0), i.e. −1.0, is exact; the product is never saturated before the add/subtract.

## Test plan
- **Identity:** a=(0x0001_0000, 0), b=(0x0001_0000, 0), twiddle=0x7fff_0000, inverse=0, scale=0 -> out_a=(0x0002_0000, 0), out_b=(0, 0), out_valid exactly 4 clocks after accept.
- **Twiddle j and inverse:** a=0, b=(0x0001_0000, 0), twiddle=0x0000_7fff:
  - inverse=0 -> out_a=(0, 0x0001_0000), out_b=(0, 0xFFFF_0000);
  - inverse=1 -> out_a=(0, 0xFFFF_0000), out_b=(0, 0x0001_0000).
- **Negative one and rounding:**
  - a=0, b=(0x0000_8000, 0), twiddle=0x8000_0000 -> out_a re=0xFFFF_8000, out_b re=0x0000_8000;
  - b=(1, 0), twiddle=0x4000_0000 -> product re=1 (rounded up).
- **Saturation and scaling:**
  - a=b=(0x7FFF_FFFF, 0), twiddle=1.0, scale=0 -> out_a re=0x7FFF_FFFF and sat_flag=1, out_b re=0;
  - after pulsing sat_clr, the same sample with scale=1 -> out_a re=0x7FFF_FFFF and sat_flag stays 0.
- **Backpressure:** stream 8 distinct samples with in_valid held at 1 while out_ready toggles 1,0,1,0,… -> the 8 outputs appear in order with none dropped or duplicated, outputs are stable during stalls, and in_ready=0 in every cycle where out_valid=1 and out_ready=0.
- **Reset mid-stream:** pull rst_n low asynchronously with 3 samples in flight -> out_valid, out_a, out_b and sat_flag go to 0 immediately; after release, no output appears until new samples are accepted, and the first new output arrives 4 clocks after its accept.
